// File: rtl/decode_pipe_stage_if.sv
// ID-stage bus: IF/ID inputs, controller fields, writeback port, EX handshake and
// the registered ID/EX outputs. The decode stage uses the slave view.
interface decode_pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
);
  logic              if_valid;
  logic [31:0]       if_instr;
  logic [DATA_W-1:0] if_pc4;
  logic [CTRL_W-1:0] ctrl_in;
  logic              ctrl_ext_sel;
  logic [1:0]        ctrl_dst_sel;
  logic              ctrl_mem_read;
  logic              ctrl_uses_rt;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              ex_ready;
  logic              ex_flush;
  logic              id_stall;
  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic              ex_mem_read;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_dst;
  logic [DATA_W-1:0] ex_pc4;

  modport master (
    output if_valid, if_instr, if_pc4, ctrl_in, ctrl_ext_sel, ctrl_dst_sel,
           ctrl_mem_read, ctrl_uses_rt, wb_we, wb_addr, wb_data, ex_ready, ex_flush,
    input  id_stall, ex_valid, ex_ctrl, ex_mem_read, ex_rs_data, ex_rt_data,
           ex_imm, ex_rs, ex_rt, ex_dst, ex_pc4
  );

  modport slave (
    input  if_valid, if_instr, if_pc4, ctrl_in, ctrl_ext_sel, ctrl_dst_sel,
           ctrl_mem_read, ctrl_uses_rt, wb_we, wb_addr, wb_data, ex_ready, ex_flush,
    output id_stall, ex_valid, ex_ctrl, ex_mem_read, ex_rs_data, ex_rt_data,
           ex_imm, ex_rs, ex_rt, ex_dst, ex_pc4
  );
endinterface

// File: rtl/decode_pipe_stage.sv
// MIPS decode stage: register file, immediate/destination decode and the ID/EX register
// with load-use interlock, back-pressure and flush. Define DECODE_PERF_EN for perf counters.
module decode_pipe_stage #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 16,
  parameter int LINK_REG = 31
) (
  input  logic clk,
  input  logic rst_n,
  decode_pipe_stage_if.slave pipe_io
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0] perf_bubble_cnt_o,
  output logic [31:0] perf_hold_cnt_o
`endif
);

  localparam logic [4:0] LINK_IDX = 5'(LINK_REG);

  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] rs_data, rt_data, imm_ext;
  logic [4:0]        dst;
  logic              v, haz;
  logic              unused_opcode;

  logic [DATA_W-1:0] rf_q [32];

  logic              ex_valid_q,    ex_valid_d;
  logic [CTRL_W-1:0] ex_ctrl_q,     ex_ctrl_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic [DATA_W-1:0] ex_rs_data_q,  ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q,  ex_rt_data_d;
  logic [DATA_W-1:0] ex_imm_q,      ex_imm_d;
  logic [4:0]        ex_rs_q,       ex_rs_d;
  logic [4:0]        ex_rt_q,       ex_rt_d;
  logic [4:0]        ex_dst_q,      ex_dst_d;
  logic [DATA_W-1:0] ex_pc4_q,      ex_pc4_d;

  assign rs            = pipe_io.if_instr[25:21];
  assign rt            = pipe_io.if_instr[20:16];
  assign rd            = pipe_io.if_instr[15:11];
  assign imm16         = pipe_io.if_instr[15:0];
  assign unused_opcode = ^pipe_io.if_instr[31:26];

  // Entry 0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        rf_q[i] <= '0;
      end
    end else if (pipe_io.wb_we && (pipe_io.wb_addr != 5'd0)) begin
      rf_q[pipe_io.wb_addr] <= pipe_io.wb_data;
    end
  end

  // Write-first reads: a same-cycle writeback to the read index is forwarded.
  always_comb begin
    rs_data = rf_q[rs];
    rt_data = rf_q[rt];
    if (rs == 5'd0) begin
      rs_data = '0;
    end else if (pipe_io.wb_we && (pipe_io.wb_addr == rs)) begin
      rs_data = pipe_io.wb_data;
    end
    if (rt == 5'd0) begin
      rt_data = '0;
    end else if (pipe_io.wb_we && (pipe_io.wb_addr == rt)) begin
      rt_data = pipe_io.wb_data;
    end
  end

  assign imm_ext = pipe_io.ctrl_ext_sel ? {{(DATA_W-16){1'b0}}, imm16}
                                        : {{(DATA_W-16){imm16[15]}}, imm16};

  always_comb begin
    dst = rt;
    unique case (pipe_io.ctrl_dst_sel)
      2'd1:    dst = rd;
      2'd2:    dst = LINK_IDX;
      default: dst = rt;
    endcase
  end

  assign v   = pipe_io.if_valid & ~pipe_io.ex_flush;
  assign haz = v & ex_valid_q & ex_mem_read_q & (ex_dst_q != 5'd0) &
               ((ex_dst_q == rs) | (pipe_io.ctrl_uses_rt & (ex_dst_q == rt)));

  // A flushed instruction has v=0, so it can neither stall nor raise a hazard.
  assign pipe_io.id_stall = pipe_io.ex_ready ? haz : v;

  always_comb begin
    ex_valid_d    = ex_valid_q;
    ex_ctrl_d     = ex_ctrl_q;
    ex_mem_read_d = ex_mem_read_q;
    ex_rs_data_d  = ex_rs_data_q;
    ex_rt_data_d  = ex_rt_data_q;
    ex_imm_d      = ex_imm_q;
    ex_rs_d       = ex_rs_q;
    ex_rt_d       = ex_rt_q;
    ex_dst_d      = ex_dst_q;
    ex_pc4_d      = ex_pc4_q;
    if (pipe_io.ex_ready) begin
      if (haz) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d    = v;
        ex_ctrl_d     = pipe_io.ctrl_in;
        ex_mem_read_d = pipe_io.ctrl_mem_read;
        ex_rs_data_d  = rs_data;
        ex_rt_data_d  = rt_data;
        ex_imm_d      = imm_ext;
        ex_rs_d       = rs;
        ex_rt_d       = rt;
        ex_dst_d      = dst;
        ex_pc4_d      = pipe_io.if_pc4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_ctrl_q     <= '0;
      ex_mem_read_q <= 1'b0;
      ex_rs_data_q  <= '0;
      ex_rt_data_q  <= '0;
      ex_imm_q      <= '0;
      ex_rs_q       <= '0;
      ex_rt_q       <= '0;
      ex_dst_q      <= '0;
      ex_pc4_q      <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_mem_read_q <= ex_mem_read_d;
      ex_rs_data_q  <= ex_rs_data_d;
      ex_rt_data_q  <= ex_rt_data_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs_q       <= ex_rs_d;
      ex_rt_q       <= ex_rt_d;
      ex_dst_q      <= ex_dst_d;
      ex_pc4_q      <= ex_pc4_d;
    end
  end

  assign pipe_io.ex_valid    = ex_valid_q;
  assign pipe_io.ex_ctrl     = ex_ctrl_q;
  assign pipe_io.ex_mem_read = ex_mem_read_q;
  assign pipe_io.ex_rs_data  = ex_rs_data_q;
  assign pipe_io.ex_rt_data  = ex_rt_data_q;
  assign pipe_io.ex_imm      = ex_imm_q;
  assign pipe_io.ex_rs       = ex_rs_q;
  assign pipe_io.ex_rt       = ex_rt_q;
  assign pipe_io.ex_dst      = ex_dst_q;
  assign pipe_io.ex_pc4      = ex_pc4_q;

`ifdef DECODE_PERF_EN
  logic [31:0] perf_bubble_q, perf_hold_q;

  // Both counters saturate at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_q <= '0;
      perf_hold_q   <= '0;
    end else begin
      if (pipe_io.ex_ready && haz && (perf_bubble_q != 32'hFFFF_FFFF)) begin
        perf_bubble_q <= perf_bubble_q + 32'd1;
      end
      if (!pipe_io.ex_ready && v && (perf_hold_q != 32'hFFFF_FFFF)) begin
        perf_hold_q <= perf_hold_q + 32'd1;
      end
    end
  end

  assign perf_bubble_cnt_o = perf_bubble_q;
  assign perf_hold_cnt_o   = perf_hold_q;
`endif

endmodule

// File: tb/tb_decode_pipe_stage.sv
// Scoreboard bench for decode_pipe_stage: the driver pushes per-cycle expectations from a
// behavioural pipeline model; a negedge monitor pops and compares them against the DUT.
module tb_decode_pipe_stage;
  localparam int DW = 32;
  localparam int CW = 16;

  typedef struct packed {
    logic        if_valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [15:0] ctrl;
    logic        ext_sel;
    logic [1:0]  dst_sel;
    logic        mem_read;
    logic        uses_rt;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_ready;
    logic        ex_flush;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] ctrl;
    logic        mem_read;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] pc4;
  } ex_t;

  typedef struct packed {
    ex_t  ex;
    logic stall;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rst64_n;
  always #5 clk = ~clk;

  decode_pipe_stage_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();
  decode_pipe_stage_if #(.DATA_W(64), .CTRL_W(CW)) bus64 ();

`ifdef DECODE_PERF_EN
  logic [31:0] perf_b, perf_h, perf_b64, perf_h64;
`endif

  decode_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .LINK_REG(31)) u_dut (
    .clk(clk), .rst_n(rst_n), .pipe_io(bus)
`ifdef DECODE_PERF_EN
    , .perf_bubble_cnt_o(perf_b), .perf_hold_cnt_o(perf_h)
`endif
  );

  decode_pipe_stage #(.DATA_W(64), .CTRL_W(CW), .LINK_REG(31)) u_dut64 (
    .clk(clk), .rst_n(rst64_n), .pipe_io(bus64)
`ifdef DECODE_PERF_EN
    , .perf_bubble_cnt_o(perf_b64), .perf_hold_cnt_o(perf_h64)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  exp_t exp_q[$];
  ex_t  m_ex;
  logic [31:0] m_rf [32];

  function automatic void check(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.ex_ready = 1'b1;
    return s;
  endfunction

  function automatic stim_t mk_r(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
    stim_t s;
    s = idle();
    s.if_valid = 1'b1;
    s.instr    = {6'h00, rs, rt, rd, 11'h020};
    s.dst_sel  = 2'd1;
    s.uses_rt  = 1'b1;
    s.pc4      = $urandom;
    s.ctrl     = 16'($urandom);
    return s;
  endfunction

  function automatic stim_t mk_lw(logic [4:0] rs, logic [4:0] rt);
    stim_t s;
    s = idle();
    s.if_valid = 1'b1;
    s.instr    = {6'h23, rs, rt, 16'h0004};
    s.mem_read = 1'b1;
    s.pc4      = $urandom;
    s.ctrl     = 16'($urandom);
    return s;
  endfunction

  function automatic logic [31:0] model_read(logic [4:0] idx, stim_t s);
    if (idx == 5'd0) return 32'd0;
    if (s.wb_we && s.wb_addr == idx) return s.wb_data;
    return m_rf[idx];
  endfunction

  function automatic void model_reset();
    m_ex = '0;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
  endfunction

  task automatic drive(input stim_t s);
    bus.if_valid      = s.if_valid;
    bus.if_instr      = s.instr;
    bus.if_pc4        = s.pc4;
    bus.ctrl_in       = s.ctrl;
    bus.ctrl_ext_sel  = s.ext_sel;
    bus.ctrl_dst_sel  = s.dst_sel;
    bus.ctrl_mem_read = s.mem_read;
    bus.ctrl_uses_rt  = s.uses_rt;
    bus.wb_we         = s.wb_we;
    bus.wb_addr       = s.wb_addr;
    bus.wb_data       = s.wb_data;
    bus.ex_ready      = s.ex_ready;
    bus.ex_flush      = s.ex_flush;
  endtask

  // One clock of stimulus; the model predicts this cycle's stall and the next ID/EX contents.
  task automatic step(input stim_t s, output logic stall_act, output logic stall_exp);
    exp_t e;
    ex_t nxt;
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    logic v, load_use;
    @(posedge clk);
    #1;
    drive(s);
    #1;
    stall_act = bus.id_stall;
    rs  = s.instr[25:21];
    rt  = s.instr[20:16];
    rd  = s.instr[15:11];
    imm = s.instr[15:0];
    v = s.if_valid && !s.ex_flush;
    load_use = v && m_ex.valid && m_ex.mem_read && (m_ex.dst != 0) &&
               ((m_ex.dst == rs) || (s.uses_rt && m_ex.dst == rt));
    stall_exp = s.ex_ready ? load_use : v;
    nxt = m_ex;
    if (s.ex_ready) begin
      if (load_use) begin
        nxt.valid = 1'b0;
      end else begin
        nxt.valid    = v;
        nxt.ctrl     = s.ctrl;
        nxt.mem_read = s.mem_read;
        nxt.rs_data  = model_read(rs, s);
        nxt.rt_data  = model_read(rt, s);
        nxt.imm      = s.ext_sel ? {16'h0000, imm} : {{16{imm[15]}}, imm};
        nxt.rs       = rs;
        nxt.rt       = rt;
        nxt.dst      = (s.dst_sel == 2'd1) ? rd : (s.dst_sel == 2'd2) ? 5'd31 : rt;
        nxt.pc4      = s.pc4;
      end
    end
    e.ex    = m_ex;
    e.stall = stall_exp;
    exp_q.push_back(e);
    m_ex = nxt;
    if (s.wb_we && s.wb_addr != 0) m_rf[s.wb_addr] = s.wb_data;
  endtask

  // Present one instruction, holding it in ID while stalled (as IF/ID would).
  task automatic issue(input stim_t s, input int n_hold, output int stalls);
    stim_t t;
    logic sa, se;
    bit done;
    stalls = 0;
    done = 1'b0;
    for (int k = 0; k < 16 && !done; k++) begin
      t = s;
      t.ex_ready = (k >= n_hold);
      step(t, sa, se);
      if (sa) stalls++;
      if (!se) done = 1'b1;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_bound: still stalled after 16 cycles, required release");
    end
  endtask

  // Monitor: one expectation per cycle, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("id_stall", 64'(bus.id_stall), 64'(e.stall));
        check("ex_valid", 64'(bus.ex_valid), 64'(e.ex.valid));
        if (e.ex.valid) begin
          check("ex_ctrl",     64'(bus.ex_ctrl),     64'(e.ex.ctrl));
          check("ex_mem_read", 64'(bus.ex_mem_read), 64'(e.ex.mem_read));
          check("ex_rs_data",  64'(bus.ex_rs_data),  64'(e.ex.rs_data));
          check("ex_rt_data",  64'(bus.ex_rt_data),  64'(e.ex.rt_data));
          check("ex_imm",      64'(bus.ex_imm),      64'(e.ex.imm));
          check("ex_rs",       64'(bus.ex_rs),       64'(e.ex.rs));
          check("ex_rt",       64'(bus.ex_rt),       64'(e.ex.rt));
          check("ex_dst",      64'(bus.ex_dst),      64'(e.ex.dst));
          check("ex_pc4",      64'(bus.ex_pc4),      64'(e.ex.pc4));
        end
      end
    end
  end

  // 64-bit instance: sign extension must reach bit 63.
  initial begin
    rst64_n = 1'b0;
    bus64.if_valid = 1'b1;      bus64.if_instr = 32'h3400_8000;
    bus64.if_pc4 = 64'd4;       bus64.ctrl_in = '0;
    bus64.ctrl_ext_sel = 1'b0;  bus64.ctrl_dst_sel = 2'd0;
    bus64.ctrl_mem_read = 1'b0; bus64.ctrl_uses_rt = 1'b0;
    bus64.wb_we = 1'b0;         bus64.wb_addr = '0;
    bus64.wb_data = '0;         bus64.ex_ready = 1'b1;
    bus64.ex_flush = 1'b0;
    @(negedge clk);
    rst64_n = 1'b1;
    @(posedge clk);
    #2;
    check("imm64_sext", bus64.ex_imm, 64'hFFFF_FFFF_FFFF_8000);
    check("valid64", 64'(bus64.ex_valid), 64'd1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    int st;
    logic sa, se;
    logic [31:0] ins;
    rst_n = 1'b0;
    drive(idle());
    model_reset();
    #12;
    check("rst_ex_valid",   64'(bus.ex_valid),   64'd0);
    check("rst_ex_rs_data", 64'(bus.ex_rs_data), 64'd0);
    check("rst_ex_imm",     64'(bus.ex_imm),     64'd0);
    check("rst_ex_pc4",     64'(bus.ex_pc4),     64'd0);
    check("rst_ex_dst",     64'(bus.ex_dst),     64'd0);
    check("rst_id_stall",   64'(bus.id_stall),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(idle(), sa, se);

    // Write-first bypass into rs, then a write to r0 that must be ignored.
    s = mk_r(5'd5, 5'd0, 5'd9);
    s.wb_we = 1'b1; s.wb_addr = 5'd5; s.wb_data = 32'hDEAD_BEEF;
    issue(s, 0, st);
    step(idle(), sa, se);
    check("bypass_rs_data", 64'(bus.ex_rs_data), 64'h0000_0000_DEAD_BEEF);
    s = mk_r(5'd0, 5'd0, 5'd9);
    s.wb_we = 1'b1; s.wb_addr = 5'd0; s.wb_data = 32'h1234_5678;
    issue(s, 0, st);
    step(idle(), sa, se);
    check("r0_rs_data", 64'(bus.ex_rs_data), 64'd0);

    // Load-use: exactly one stall, then the consumer reaches EX.
    issue(mk_lw(5'd1, 5'd8), 0, st);
    issue(mk_r(5'd8, 5'd2, 5'd9), 0, st);
    check("loaduse_stalls", 64'(st), 64'd1);
    step(idle(), sa, se);
    check("loaduse_ex_rs", 64'(bus.ex_rs), 64'd8);
    issue(mk_lw(5'd1, 5'd8), 0, st);
    issue(mk_r(5'd3, 5'd2, 5'd9), 0, st);
    check("indep_stalls", 64'(st), 64'd0);
    issue(mk_lw(5'd1, 5'd0), 0, st);
    issue(mk_r(5'd0, 5'd0, 5'd9), 0, st);
    check("lw_r0_stalls", 64'(st), 64'd0);

    // Back-pressure for three cycles.
    issue(mk_r(5'd4, 5'd6, 5'd7), 3, st);
    check("hold_stalls", 64'(st), 64'd3);
    step(idle(), sa, se);
    check("hold_enter_rs", 64'(bus.ex_rs), 64'd4);

    // Flush over a pending hazard.
    issue(mk_lw(5'd1, 5'd8), 0, st);
    s = mk_r(5'd8, 5'd2, 5'd9);
    s.ex_flush = 1'b1;
    issue(s, 0, st);
    check("flush_stalls", 64'(st), 64'd0);
    step(idle(), sa, se);
    check("flush_ex_valid", 64'(bus.ex_valid), 64'd0);

    // Immediate extension and link destination.
    s = idle();
    s.if_valid = 1'b1; s.instr = {6'h0d, 5'd1, 5'd2, 16'h8000}; s.dst_sel = 2'd2;
    issue(s, 0, st);
    step(idle(), sa, se);
    check("imm_sext", 64'(bus.ex_imm), 64'h0000_0000_FFFF_8000);
    check("dst_link", 64'(bus.ex_dst), 64'd31);
    s.ext_sel = 1'b1;
    issue(s, 0, st);
    step(idle(), sa, se);
    check("imm_zext", 64'(bus.ex_imm), 64'h0000_0000_0000_8000);

    // Asynchronous reset while a load reading r5 sits in EX.
    issue(mk_lw(5'd5, 5'd10), 0, st);
    step(idle(), sa, se);
    @(negedge clk);
    #1;
    check("pre_rst_valid", 64'(bus.ex_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ex_valid",   64'(bus.ex_valid),   64'd0);
    check("midrst_ex_rs_data", 64'(bus.ex_rs_data), 64'd0);
    model_reset();
    drive(idle());
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    issue(mk_r(5'd5, 5'd0, 5'd9), 0, st);
    step(idle(), sa, se);
    check("post_rst_r5", 64'(bus.ex_rs_data), 64'd0);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      ins[25:21] = 5'($urandom_range(0, 9));
      ins[20:16] = 5'($urandom_range(0, 9));
      ins[15:11] = 5'($urandom_range(0, 9));
      s.if_valid = ($urandom % 8) != 0;
      s.instr    = ins;
      s.pc4      = $urandom;
      s.ctrl     = 16'($urandom);
      s.ext_sel  = 1'($urandom);
      s.dst_sel  = 2'($urandom);
      s.mem_read = ($urandom % 3) == 0;
      s.uses_rt  = 1'($urandom);
      s.wb_we    = 1'($urandom);
      s.wb_addr  = 5'($urandom_range(0, 9));
      s.wb_data  = $urandom;
      s.ex_ready = 1'b1;
      s.ex_flush = ($urandom % 10) == 0;
      issue(s, (($urandom % 6) == 0) ? int'($urandom_range(1, 3)) : 0, st);
    end

    repeat (3) step(idle(), sa, se);
    repeat (2) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_pipe_stage.md
Name: decode_pipe_stage

Overview:
Parametrised successor to the single-cycle decode block. Holds the register file, immediate extender and destination-register select, and adds a registered ID/EX pipeline boundary with a load-use hazard detector, downstream back-pressure and flush. It sits between the IF/ID register and the execute stage of the pipelined MIPS datapath. Control-word generation stays in the external controller, whose outputs feed this block.

Parameters:
DATA_W, 32, datapath width for register data, PC+4 and the extended immediate (32 or 64).
CTRL_W, 16, width of the opaque controller bundle carried to EX.
LINK_REG, 31, register index written when dst_sel selects link.

Ports:
Clock  in  1  rising-edge clock
Reset  in  1  asynchronous, active-low reset
if_valid  in  1  IF/ID holds a valid instruction
if_instr  in  32  instruction word
if_pc4  in  DATA_W  PC+4 of the instruction
ctrl_in  in  CTRL_W  controller bundle, passed through to EX
ctrl_ext_sel  in  1  0 = sign-extend imm16, 1 = zero-extend
ctrl_dst_sel  in  2  0 = rt, 1 = rd, 2 = LINK_REG, 3 = rt
ctrl_mem_read  in  1  instruction is a load
ctrl_uses_rt  in  1  instruction reads rt as a source
wb_we  in  1  writeback enable
wb_addr  in  5  writeback register
wb_data  in  DATA_W  writeback data
ex_ready  in  1  EX accepts a new ID/EX entry this cycle
ex_flush  in  1  squash the instruction currently in ID
id_stall  out  1  hold PC and IF/ID (combinational)
ex_valid  out  1  ID/EX entry valid
ex_ctrl  out  CTRL_W  registered ctrl_in
ex_mem_read  out  1  registered ctrl_mem_read
ex_rs_data  out  DATA_W  registered rs operand
ex_rt_data  out  DATA_W  registered rt operand
ex_imm  out  DATA_W  registered extended immediate
ex_rs, ex_rt  out  5 each  registered source indices
ex_dst  out  5  registered destination index
ex_pc4  out  DATA_W  registered PC+4

Behaviour:
- Reset low: all ex_* outputs cleared to 0, including ex_valid, and all 32 registers cleared to 0. Reset acts immediately, mid-operation included. The first capture occurs on the first rising edge after release.
- Register file: 32 x DATA_W. Register 0 reads 0 and ignores writes. The write happens on the Clock edge when wb_we=1 and wb_addr != 0. Reads are combinational and write-first: if wb_we=1 and wb_addr equals a nonzero read index, the read returns wb_data in the same cycle.
- Fields: rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], imm16 = instr[15:0]. Extension is sign or zero to DATA_W according to ctrl_ext_sel.
- Effective valid: v = if_valid & ~ex_flush.
- Hazard: haz = v & ex_valid & ex_mem_read & (ex_dst != 0) & ((ex_dst == rs) | (ctrl_uses_rt & (ex_dst == rt))).
- Priority per edge:
  1. ex_ready=0: ID/EX holds all contents; id_stall = v.
  2. haz=1: bubble. ex_valid <= 0, other ex_* are don't-care (implementation holds them), id_stall = 1.
  3. Otherwise: ID/EX loads all fields; ex_valid <= v; id_stall = 0.
- ex_flush with ex_ready=1: bubble loaded, id_stall=0. ex_flush with ex_ready=0: ID/EX holds, id_stall=0, because the flushed instruction is discarded by IF/ID.
- A load followed by an independent instruction gives no stall. A load targeting register 0 never stalls.
- Latency: one cycle from ID inputs to ex_* when unstalled. Load-use costs exactly one bubble.
- Throughput: one instruction per cycle with no hazards and ex_ready=1.

Optional Feature:
DECODE_PERF_EN
- Defined: adds two 32-bit saturating output counters.
  - perf_bubble_cnt increments on each hazard bubble.
  - perf_hold_cnt increments on each cycle with ex_ready=0 and v=1.
  - Both reset to 0 and stick at 0xFFFFFFFF.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset mid-stream: assert Reset low during a valid load -> ex_valid=0 and ex_rs_data=0 immediately. After release, reading r5 returns 0.
- Write-first bypass: wb_we=1, wb_addr=5, wb_data=0xDEADBEEF, same-cycle decode of add using rs=5 -> ex_rs_data=0xDEADBEEF next edge. Write to r0 -> reads stay 0.
- Load-use: lw r8 then add r9,r8,r2 -> id_stall=1 for one cycle, one bubble (ex_valid=0), then add in EX with ex_rs=8. lw r8 then add r9,r3,r2 -> no stall.
- Back-pressure: ex_ready=0 for 3 cycles with a valid instruction in ID -> ex_* unchanged, id_stall=1 for 3 cycles, instruction enters EX on the 4th edge.
- Flush: ex_flush=1 with if_valid=1, ex_ready=1 -> ex_valid=0 next cycle, id_stall=0. Flush during a pending hazard -> no stall.
- Immediate/dst: imm16=0x8000, ext_sel=0 -> 0xFFFF8000; ext_sel=1 -> 0x00008000. dst_sel=2 -> ex_dst=31. With DATA_W=64, sign extension reaches bit 63.
